// File: rtl/sync_rx_fifo.sv
// Receive-side consumer for the DataSync crossing: captures each synchronised word
// exactly once into a small first-word-fall-through FIFO and serves it as a valid/ready stream.
module sync_rx_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_valid,
  output logic                  in_data_retrieved,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CW-1:0]         count,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_DROP} state_t;

  state_t                state_q;
  logic                  retrieved_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic push;
  logic pop;

  assign full    = (count_q == CW'(DEPTH));
  assign m_valid = (count_q != '0);
  assign count   = count_q;
  assign m_data  = mem[rd_ptr_q];

  assign in_data_retrieved = retrieved_q;

  // Push uses the pre-edge occupancy, so a same-cycle pop never frees room for it.
  assign push = (state_q == IDLE) && in_data_valid && !full;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is left unreset so it maps onto plain distributed/block memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      retrieved_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        IDLE: begin
          retrieved_q <= 1'b0;
          if (push) begin
            state_q     <= ACK;
            retrieved_q <= 1'b1;
          end
        end
        ACK: begin
          state_q     <= WAIT_DROP;
          retrieved_q <= 1'b0;
        end
        WAIT_DROP: begin
          // Valid lingers while the retrieval crosses back; re-arm only once it drops.
          retrieved_q <= 1'b0;
          if (!in_data_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          retrieved_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
